// File: rtl/adder_pkg.sv
// adder_pkg: shared constants and types for the fa_8_bit ripple-carry adder.
//   ADDER_WIDTH    : default operand/sum width.
//   adder_result_t : {co, sum}, the full (ADDER_WIDTH+1)-bit result of a + b + cin.
package adder_pkg;

  localparam int ADDER_WIDTH = 8;

  typedef struct packed {
    logic                   co;
    logic [ADDER_WIDTH-1:0] sum;
  } adder_result_t;

endpackage : adder_pkg

// File: rtl/fa_8_bit_full_adder_1b.sv
// full_adder_1b: single-bit combinational full adder cell.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit  = a ^ b ^ cin
//   cout : carry out = generate | (propagate & cin)
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder_1b

// File: rtl/fa_8_bit.sv
// fa_8_bit: registered WIDTH-bit ripple-carry adder with carry-in.
//   clk       : rising-edge clock
//   rst       : asynchronous, active-high reset (clears all outputs)
//   in_valid  : a/b/cin are valid; result is captured on the next rising edge
//   a, b      : unsigned operands
//   cin       : carry into bit 0
//   sum       : registered low WIDTH bits of a + b + cin
//   co_bit_8  : registered carry out of bit WIDTH-1
//   out_valid : sum/co_bit_8 hold a result captured from an in_valid cycle
//
// Handshake: valid-only, no backpressure. Each in_valid cycle yields exactly
// one result one cycle later with out_valid=1; cycles without in_valid leave
// sum/co_bit_8 unchanged and drop out_valid.
module fa_8_bit
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             co_bit_8,
  output logic             out_valid
);

  logic [WIDTH-1:0] core_sum;
  logic             core_co;

  // Each cell keeps its carry in its own generate scope so the chain is a
  // set of distinct nets rather than one vector feeding back into itself.
  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    logic carry_in;
    logic carry_out;

    if (i == 0) begin : gen_first
      assign carry_in = cin;
    end else begin : gen_rest
      assign carry_in = gen_bit[i-1].carry_out;
    end

    full_adder_1b u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry_in),
      .s    (core_sum[i]),
      .cout (carry_out)
    );
  end

  assign core_co = gen_bit[WIDTH-1].carry_out;

  // Output register
  logic [WIDTH-1:0] sum_d,       sum_q;
  logic             co_d,        co_q;
  logic             out_valid_d, out_valid_q;

  always_comb begin
    sum_d       = sum_q;
    co_d        = co_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d = core_sum;
      co_d  = core_co;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      co_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      co_q        <= co_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign co_bit_8  = co_q;
  assign out_valid = out_valid_q;

endmodule : fa_8_bit

// File: tb/tb_fa_8_bit.sv
// tb_fa_8_bit: self-checking bench for fa_8_bit.
module tb_fa_8_bit;
  import adder_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] sum;
  logic         co_bit_8;
  logic         out_valid;

  always #5 clk = ~clk;

  fa_8_bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .co_bit_8  (co_bit_8),
    .out_valid (out_valid)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Result is plain integer addition at W+1 bits; registered like the spec says.
  adder_result_t m_res   = '0;
  logic          m_valid = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_res   <= '0;
      m_valid <= 1'b0;
    end else if (in_valid) begin
      m_res   <= adder_result_t'(int'(a) + int'(b) + int'(cin));
      m_valid <= 1'b1;
    end else begin
      m_valid <= 1'b0;
    end
  end

  // ---------------- compare process ----------------
  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_sum",   32'(sum),       32'(m_res.sum));
      check("model_co",    32'(co_bit_8),  32'(m_res.co));
      check("model_valid", 32'(out_valid), 32'(m_valid));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
    in_valid = v;
    a        = ai;
    b        = bi;
    cin      = ci;
  endtask

  // Drive one add at a negedge, then check the literal result one negedge later.
  task automatic add_check(input string name, input logic [W-1:0] ai, input logic [W-1:0] bi,
                           input logic ci, input logic [W-1:0] exp_sum, input logic exp_co);
    @(negedge clk);
    drive(1'b1, ai, bi, ci);
    @(negedge clk);
    check({name, "_sum"},   32'(sum),       32'(exp_sum));
    check({name, "_co"},    32'(co_bit_8),  32'(exp_co));
    check({name, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reset with a live input: nothing may be captured.
    drive(1'b1, 8'h55, 8'h00, 1'b0);
    #1 rst = 1'b1;
    #2;
    check("rst_sum",   32'(sum),       32'd0);
    check("rst_co",    32'(co_bit_8),  32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_hold_sum",   32'(sum),       32'd0);
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    cmp_en = 1'b1;
    rst    = 1'b0;
    drive(1'b0, '0, '0, 1'b0);

    // Basic adds
    add_check("add_1_1",   8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    add_check("add_3_1",   8'h03, 8'h01, 1'b0, 8'h04, 1'b0);
    add_check("add_7f_7f", 8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0);
    // Carry ripple / wrap / max / zero
    add_check("wrap_ff_1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    add_check("add_0f_0f", 8'h0F, 8'h0F, 1'b1, 8'h1F, 1'b0);
    add_check("max_ff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    add_check("zero",      8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // Hold: in_valid=0 keeps the last result and drops out_valid
    add_check("hold_pre", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    drive(1'b0, 8'hAA, 8'h11, 1'b0);
    @(negedge clk);
    check("hold_sum",   32'(sum),       32'h02);
    check("hold_co",    32'(co_bit_8),  32'd0);
    check("hold_valid", 32'(out_valid), 32'd0);

    // Random sweep, back-to-back, with a reset pulse mid-stream
    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 9) != 0), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      if (i == 500) begin
        #2 rst = 1'b1;
        #1;
        check("mid_rst_sum",   32'(sum),       32'd0);
        check("mid_rst_co",    32'(co_bit_8),  32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        continue;
      end
      @(negedge clk);
    end

    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fa_8_bit
